// File: rtl/gpr_scoreboard_rf.sv
// gpr_scoreboard_rf
// ------------------
// General-purpose register file (r1..r31, r0 reads as zero) with a scoreboard
// of pending writes. Decode issues destination registers, writeback retires
// them. Decode sees bypassed read data and a per-port "operand ready" flag,
// so it can stall on read-after-write hazards.
//
// Ports
//   clk             system clock, all state updates on the rising edge
//   rst             synchronous, active-high reset
//   wb_regfile_bus  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]} from WB.
//                   rf_we is already qualified by WB valid.
//   id_issue_valid  decode hands an instruction to EXE this cycle
//   id_issue_we     the issued instruction writes a GPR
//   id_issue_dest   destination register of the issued instruction
//   id_issue_ok     issue permitted; low only when the dest counter is full
//   raddr1/raddr2   read-port addresses
//   rdata1/rdata2   read data with write-through bypass from WB
//   rready1/rready2 operand has no outstanding older write
//   sb_error        sticky: a retire was seen for a register with no pending write
//
// Handshake: an issue takes effect only when id_issue_valid and id_issue_ok
// are both high at the clock edge. While id_issue_ok is low the issuer holds
// the instruction; a blocked issue leaves every counter untouched. The WB bus
// has no back-pressure: rf_we=1 is always accepted.
module gpr_scoreboard_rf #(
    // In-flight writes per register (EXE, MEM, WB). Must fit in 2 bits.
    parameter int unsigned MAX_PEND = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [37:0] wb_regfile_bus,
    input  logic        id_issue_valid,
    input  logic        id_issue_we,
    input  logic [4:0]  id_issue_dest,
    output logic        id_issue_ok,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        rready1,
    output logic        rready2,
    output logic        sb_error
);

    localparam logic [1:0] PEND_FULL = MAX_PEND[1:0];

    // Unpack the writeback bus.
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign rf_we    = wb_regfile_bus[37];
    assign rf_waddr = wb_regfile_bus[36:32];
    assign rf_wdata = wb_regfile_bus[31:0];

    // Entry 0 of both arrays is reset to zero and never written, so r0
    // behaves as hard-wired zero and its pending count stays at zero.
    logic [31:0] regs      [32];
    logic [1:0]  pend      [32];
    logic [1:0]  pend_next [32];
    logic        err_set;

    logic        inc;
    logic        dec;
    logic [31:0] inc_hit;
    logic [31:0] dec_hit;

    assign dec = rf_we && (rf_waddr != 5'd0);

    // A retire to the same register frees a slot in this very cycle, so a
    // full counter does not block the issue in that case.
    assign id_issue_ok = !(id_issue_we && (id_issue_dest != 5'd0) &&
                           (pend[id_issue_dest] == PEND_FULL) &&
                           !(dec && (rf_waddr == id_issue_dest)));

    assign inc = id_issue_valid && id_issue_ok && id_issue_we &&
                 (id_issue_dest != 5'd0);

    assign inc_hit = inc ? (32'd1 << id_issue_dest) : 32'd0;
    assign dec_hit = dec ? (32'd1 << rf_waddr)      : 32'd0;

    // Next pending counts. Issue and retire on the same register cancel out.
    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < 32; i++) begin
            pend_next[i] = pend[i];
            if (inc_hit[i] && !dec_hit[i]) begin
                pend_next[i] = pend[i] + 2'd1;
            end else if (dec_hit[i] && !inc_hit[i]) begin
                if (pend[i] == 2'd0) begin
                    err_set = 1'b1;
                end else begin
                    pend_next[i] = pend[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
                pend[i] <= 2'd0;
            end
            sb_error <= 1'b0;
        end else begin
            if (dec) begin
                regs[rf_waddr] <= rf_wdata;
            end
            for (int i = 0; i < 32; i++) begin
                pend[i] <= pend_next[i];
            end
            if (err_set) begin
                sb_error <= 1'b1;
            end
        end
    end

    // Read ports: zero for r0, WB bypass, else storage.
    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == 5'd0) begin
            rdata1 = 32'd0;
        end else if (rf_we && (rf_waddr == raddr1)) begin
            rdata1 = rf_wdata;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == 5'd0) begin
            rdata2 = 32'd0;
        end else if (rf_we && (rf_waddr == raddr2)) begin
            rdata2 = rf_wdata;
        end
    end

    // Ready when nothing is pending, or the last pending write is retiring
    // now and its data arrives through the bypass. Same-cycle issues are
    // deliberately not considered: they only count from the next edge.
    assign rready1 = (raddr1 == 5'd0) || (pend[raddr1] == 2'd0) ||
                     ((pend[raddr1] == 2'd1) && dec && (rf_waddr == raddr1));
    assign rready2 = (raddr2 == 5'd0) || (pend[raddr2] == 2'd0) ||
                     ((pend[raddr2] == 2'd1) && dec && (rf_waddr == raddr2));

endmodule

// File: tb/tb_gpr_scoreboard_rf.sv
// Testbench for gpr_scoreboard_rf: directed scenarios followed by random
// traffic, all outputs compared each cycle against a reference model that
// keeps register contents and per-register in-flight counts as plain ints.
module tb_gpr_scoreboard_rf;

  logic        clk;
  logic        rst;
  logic [37:0] wb_regfile_bus;
  logic        id_issue_valid;
  logic        id_issue_we;
  logic [4:0]  id_issue_dest;
  logic        id_issue_ok;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        rready1;
  logic        rready2;
  logic        sb_error;

  gpr_scoreboard_rf dut (
    .clk            (clk),
    .rst            (rst),
    .wb_regfile_bus (wb_regfile_bus),
    .id_issue_valid (id_issue_valid),
    .id_issue_we    (id_issue_we),
    .id_issue_dest  (id_issue_dest),
    .id_issue_ok    (id_issue_ok),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .rready1        (rready1),
    .rready2        (rready2),
    .sb_error       (sb_error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  int          m_pend [32];
  bit          m_err;

  // Values observed in the most recent cycle, for directed spot checks.
  logic [31:0] last_rd1;
  logic        last_rr1;
  logic        last_rr2;
  logic        last_ok;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit we, input logic [4:0] wa,
                                         input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_ready(input logic [4:0] a, input bit we, input logic [4:0] wa);
    if (a == 0) return 1'b1;
    if (m_pend[a] == 0) return 1'b1;
    if (m_pend[a] == 1 && we && wa == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    wb_regfile_bus = '0;
    id_issue_valid = 1'b0;
    id_issue_we    = 1'b0;
    id_issue_dest  = '0;
    raddr1         = '0;
    raddr2         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called just after a rising edge. Drives inputs, compares every output
  // with the model at the falling edge, then advances the model at the
  // next rising edge.
  task automatic cycle(input bit iv, input bit iw, input logic [4:0] idst,
                       input bit wwe, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    bit ok_exp;
    bit wr;
    id_issue_valid = iv;
    id_issue_we    = iw;
    id_issue_dest  = idst;
    wb_regfile_bus = {wwe, wa, wd};
    raddr1         = a1;
    raddr2         = a2;

    ok_exp = !(iw && idst != 0 && m_pend[idst] >= 3 && !(wwe && wa == idst));

    @(negedge clk);
    check("rdata1",   rdata1,  m_read(a1, wwe, wa, wd));
    check("rdata2",   rdata2,  m_read(a2, wwe, wa, wd));
    check("rready1",  32'(rready1),  32'(m_ready(a1, wwe, wa)));
    check("rready2",  32'(rready2),  32'(m_ready(a2, wwe, wa)));
    check("issue_ok", 32'(id_issue_ok), 32'(ok_exp));
    check("sb_error", 32'(sb_error), 32'(m_err));
    last_rd1 = rdata1;
    last_rr1 = rready1;
    last_rr2 = rready2;
    last_ok  = id_issue_ok;
    last_err = sb_error;

    @(posedge clk);
    // A write retires one in-flight instruction; an accepted issue adds one.
    wr = wwe && wa != 0;
    if (wr) m_regs[wa] = wd;
    if (iv && ok_exp && iw && idst != 0) m_pend[idst] = m_pend[idst] + 1;
    if (wr) begin
      if (m_pend[wa] == 0) m_err = 1'b1;
      else m_pend[wa] = m_pend[wa] - 1;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cycle(0, 0, 0, 0, 0, 32'd0, a1, a2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    model_reset();
    do_reset();

    // Reset state.
    idle(0, 5);
    check("rst_rd1",  last_rd1, 32'd0);
    check("rst_rr2",  32'(last_rr2), 32'd1);
    check("rst_ok",   32'(last_ok),  32'd1);
    check("rst_err",  32'(last_err), 32'd0);

    // Issue r5, stall window, retire with bypass.
    cycle(1, 1, 5, 0, 0, 32'd0, 5, 0);
    for (int i = 0; i < 3; i++) begin
      idle(5, 0);
      check("r5_wait_rr", 32'(last_rr1), 32'd0);
    end
    cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
    check("r5_byp_rr", 32'(last_rr1), 32'd1);
    check("r5_byp_rd", last_rd1, 32'hDEADBEEF);
    idle(5, 0);
    check("r5_store_rd", last_rd1, 32'hDEADBEEF);
    check("r5_store_rr", 32'(last_rr1), 32'd1);

    // Saturate r7.
    for (int i = 0; i < 3; i++) cycle(1, 1, 7, 0, 0, 32'd0, 7, 0);
    cycle(1, 1, 7, 0, 0, 32'd0, 7, 0);
    check("r7_full_ok", 32'(last_ok), 32'd0);
    cycle(1, 1, 7, 1, 7, 32'h0000_0070, 7, 0);
    check("r7_ret_ok", 32'(last_ok), 32'd1);
    check("r7_ret_rr", 32'(last_rr1), 32'd0);
    cycle(1, 1, 7, 0, 0, 32'd0, 7, 0);
    check("r7_still_full", 32'(last_ok), 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 7, 32'h71 + i, 7, 0);
    check("r7_last_ret_rr", 32'(last_rr1), 32'd1);
    idle(7, 0);
    check("r7_drained", last_rd1, 32'h73);

    // Simultaneous issue and retire on r9 at pend=1.
    cycle(1, 1, 9, 0, 0, 32'd0, 9, 0);
    cycle(1, 1, 9, 1, 9, 32'h99, 9, 0);
    check("r9_same_rr", 32'(last_rr1), 32'd1);
    idle(9, 0);
    check("r9_next_rr", 32'(last_rr1), 32'd0);
    cycle(0, 0, 0, 1, 9, 32'h9A, 9, 0);

    // r0 writes and issues.
    cycle(0, 0, 0, 1, 0, 32'h12345678, 0, 0);
    check("r0_rd", last_rd1, 32'd0);
    cycle(1, 1, 0, 0, 0, 32'd0, 0, 0);
    check("r0_issue_ok", 32'(last_ok), 32'd1);
    idle(0, 0);
    check("r0_rr", 32'(last_rr1), 32'd1);

    // Retire with nothing pending.
    cycle(0, 0, 0, 1, 3, 32'h33, 3, 0);
    idle(3, 0);
    check("err_set", 32'(last_err), 32'd1);
    check("err_r3_rr", 32'(last_rr1), 32'd1);
    idle(3, 0);
    check("err_sticky", 32'(last_err), 32'd1);
    do_reset();
    idle(3, 0);
    check("err_cleared", 32'(last_err), 32'd0);
    check("r3_cleared", last_rd1, 32'd0);

    // Random traffic on a small register window to hit saturation often.
    for (int n = 0; n < 3000; n++) begin
      bit          iv, iw, wwe;
      logic [4:0]  idst, wa, a1, a2;
      iv   = $urandom_range(0, 1);
      iw   = $urandom_range(0, 3) != 0;
      idst = 5'($urandom_range(0, 7));
      wwe  = $urandom_range(0, 2) == 0;
      wa   = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) wa = 5'($urandom_range(0, 31));
      a1   = 5'($urandom_range(0, 8));
      a2   = 5'($urandom_range(0, 31));
      cycle(iv, iw, idst, wwe, wa, $urandom, a1, a2);
      if (n == 1500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
